// File: rtl/root_power_arbiter.sv
// root_power_arbiter: per-bank round-robin arbiter granting NTT/INTT requesters bursts on root-power RAM banks.
// Define ROOT_ARB_DRAIN_EN to add the post-burst DRAIN state; otherwise BURST returns straight to IDLE.
module root_power_arbiter #(
    parameter int NTT_INTT_NUM   = 4,
    parameter int ROOT_POWER_NUM = 4,
    parameter int LEN_W          = 12,
    parameter int DRAIN_CYCLES   = 2,
    localparam int BW = ROOT_POWER_NUM > 1 ? $clog2(ROOT_POWER_NUM) : 1,
    localparam int IW = NTT_INTT_NUM > 1 ? $clog2(NTT_INTT_NUM) : 1
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic [NTT_INTT_NUM-1:0]                   req,
    input  logic [NTT_INTT_NUM-1:0][BW-1:0]           req_bank,
    input  logic [NTT_INTT_NUM-1:0][LEN_W-1:0]        req_len,
    output logic [NTT_INTT_NUM-1:0]                   gnt,
    output logic [ROOT_POWER_NUM-1:0][IW-1:0]         ntt_intt_select,
    output logic [NTT_INTT_NUM-1:0][BW-1:0]           root_select,
    output logic [ROOT_POWER_NUM-1:0]                 bank_busy,
    output logic [NTT_INTT_NUM-1:0]                   owner_active
);
`ifdef ROOT_ARB_DRAIN_EN
    localparam bit DRAIN_EN = 1'b1;
`else
    localparam bit DRAIN_EN = 1'b0;
`endif
    localparam bit HAS_DRAIN = DRAIN_EN && DRAIN_CYCLES > 0;
    localparam logic [LEN_W-1:0] DRAIN_LEN = LEN_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} state_e;

    state_e            state_q [ROOT_POWER_NUM];
    state_e            state_d [ROOT_POWER_NUM];
    logic [LEN_W-1:0]  cnt_q   [ROOT_POWER_NUM];
    logic [LEN_W-1:0]  cnt_d   [ROOT_POWER_NUM];
    logic [IW-1:0]     ptr_q   [ROOT_POWER_NUM];
    logic [IW-1:0]     ptr_d   [ROOT_POWER_NUM];
    logic [IW-1:0]     owner_q [ROOT_POWER_NUM];
    logic [IW-1:0]     owner_d [ROOT_POWER_NUM];
    logic [NTT_INTT_NUM-1:0] gnt_q, gnt_d;

    assign gnt = gnt_q;

    // Select paths are decoded from registered ownership, so they stay stable GRANT..last busy cycle.
    always_comb begin
        ntt_intt_select = '0;
        root_select     = '0;
        bank_busy       = '0;
        owner_active    = '0;
        for (int b = 0; b < ROOT_POWER_NUM; b++) begin
            if (state_q[b] != IDLE) begin
                bank_busy[b]                = 1'b1;
                ntt_intt_select[b]          = owner_q[b];
                root_select[owner_q[b]]     = BW'(b);
                owner_active[owner_q[b]]    = 1'b1;
            end
        end
    end

    always_comb begin
        logic          found;
        logic [IW-1:0] win;
        int            idx;
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = '0;
        for (int b = 0; b < ROOT_POWER_NUM; b++) begin
            found = 1'b0;
            win   = '0;
            for (int k = 0; k < NTT_INTT_NUM; k++) begin
                idx = (int'(ptr_q[b]) + k) % NTT_INTT_NUM;
                if (!found && req[idx] && req_bank[idx] == BW'(b) && !owner_active[idx]) begin
                    found = 1'b1;
                    win   = IW'(idx);
                end
            end
            case (state_q[b])
                IDLE: if (found) begin
                    state_d[b] = GRANT;
                    owner_d[b] = win;
                    ptr_d[b]   = IW'((int'(win) + 1) % NTT_INTT_NUM);
                    gnt_d[win] = 1'b1;
                    cnt_d[b]   = req_len[win] == '0 ? LEN_W'(1) : req_len[win];
                end
                GRANT: state_d[b] = BURST;
                BURST: begin
                    cnt_d[b] = cnt_q[b] - LEN_W'(1);
                    if (cnt_q[b] == LEN_W'(1)) begin
                        state_d[b] = HAS_DRAIN ? DRAIN : IDLE;
                        cnt_d[b]   = HAS_DRAIN ? DRAIN_LEN : '0;
                    end
                end
                default: begin
                    cnt_d[b] = cnt_q[b] - LEN_W'(1);
                    if (cnt_q[b] <= LEN_W'(1)) begin
                        state_d[b] = IDLE;
                        cnt_d[b]   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < ROOT_POWER_NUM; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= '0;
                ptr_q[b]   <= '0;
                owner_q[b] <= '0;
            end
            gnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
        end
    end
endmodule

// File: tb/tb_root_power_arbiter.sv
// tb_root_power_arbiter: directed checks of grant timing, round-robin order, ownership paths and reset.
// Expected bank occupancy follows ROOT_ARB_DRAIN_EN (DRAIN of 2 cycles when defined, none otherwise).
module tb_root_power_arbiter;
`ifdef ROOT_ARB_DRAIN_EN
    localparam int DR = 2;
`else
    localparam int DR = 0;
`endif
    localparam int P = 3 + DR;

    logic             clk = 1'b0;
    logic             rstn;
    logic [3:0]       req;
    logic [3:0][1:0]  req_bank;
    logic [3:0][11:0] req_len;
    logic [3:0]       gnt;
    logic [3:0][1:0]  ntt_intt_select;
    logic [3:0][1:0]  root_select;
    logic [3:0]       bank_busy;
    logic [3:0]       owner_active;
    int               errs = 0;
    int               checks = 0;

    root_power_arbiter dut (
        .clk(clk), .rstn(rstn), .req(req), .req_bank(req_bank), .req_len(req_len),
        .gnt(gnt), .ntt_intt_select(ntt_intt_select), .root_select(root_select),
        .bank_busy(bank_busy), .owner_active(owner_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_busy"}, 32'(bank_busy), 0);
        check({tag, "_own"}, 32'(owner_active), 0);
        check({tag, "_nsel"}, 32'(ntt_intt_select), 0);
        check({tag, "_rsel"}, 32'(root_select), 0);
    endtask

    initial begin
        rstn = 1'b0; req = '0; req_bank = '0; req_len = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // single requester, bank0, len 4
        req[0] = 1'b1; req_bank[0] = 2'd0; req_len[0] = 12'd4;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            check("single_gnt", 32'(gnt), n == 1 ? 1 : 0);
            check("single_busy", 32'(bank_busy[0]), 32'(n <= 5 + DR));
            check("single_nsel", 32'(ntt_intt_select[0]), 0);
            check("single_rsel", 32'(root_select[0]), 0);
            if (n == 1) begin
                check("single_own", 32'(owner_active), 1);
                req[0] = 1'b0;
            end
        end

        // all four to bank2, len 1, held: round robin 0,1,2,3
        for (int i = 0; i < 4; i++) begin
            req_bank[i] = 2'd2; req_len[i] = 12'd1;
        end
        req = 4'b1111;
        for (int n = 1; n <= 4 * P; n++) begin
            int k;
            logic [3:0] e;
            @(negedge clk);
            k = (n - 1) / P;
            e = ((n - 1) % P == 0) ? 4'(1 << k) : 4'd0;
            check("rr_gnt", 32'(gnt), 32'(e));
            if (e != 0) begin
                check("rr_nsel", 32'(ntt_intt_select[2]), k);
                req[k] = 1'b0;
            end
        end
        check("rr_idle", 32'(bank_busy), 0);

        // req0 -> bank1, req3 -> bank0 together; req1 queues on busy bank0
        req_bank[0] = 2'd1; req_len[0] = 12'd3;
        req_bank[3] = 2'd0; req_len[3] = 12'd3;
        req = 4'b1001;
        for (int n = 1; n <= 6 + DR; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("dual_gnt", 32'(gnt), 32'h9);
                check("dual_rsel", 32'(root_select), 32'h01);
                check("dual_nsel", 32'(ntt_intt_select), 32'h03);
                check("dual_own", 32'(owner_active), 32'h9);
                check("dual_busy", 32'(bank_busy), 32'h3);
                req = 4'b0010; req_bank[1] = 2'd0; req_len[1] = 12'd2;
            end else if (n == 4) begin
                check("dual_rsel_hold", 32'(root_select), 32'h01);
                check("dual_nsel_hold", 32'(ntt_intt_select), 32'h03);
                check("wait_gnt", 32'(gnt), 0);
            end else if (n == 6 + DR) begin
                check("wait_gnt", 32'(gnt), 32'h2);
                check("wait_nsel", 32'(ntt_intt_select), 32'h01);
                check("wait_own", 32'(owner_active), 32'h2);
                req = '0;
            end else begin
                check("wait_gnt", 32'(gnt), 0);
            end
        end
        repeat (10) @(negedge clk);
        check("dual_idle", 32'(bank_busy), 0);

        // len 0 behaves as a 1-cycle burst
        req_bank[2] = 2'd3; req_len[2] = 12'd0; req[2] = 1'b1;
        for (int n = 1; n <= 4 + DR; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("len0_gnt", 32'(gnt), 32'h4);
                req[2] = 1'b0;
            end
            check("len0_busy", 32'(bank_busy[3]), 32'(n <= 2 + DR));
        end

        // asynchronous reset in the middle of a long burst
        req_bank[1] = 2'd1; req_len[1] = 12'd100; req[1] = 1'b1;
        @(negedge clk);
        check("long_gnt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        repeat (5) @(negedge clk);
        check("long_busy", 32'(bank_busy), 32'h2);
        #2 rstn = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rstn = 1'b1;
        req[1] = 1'b1;
        @(negedge clk);
        check("rerequest_gnt", 32'(gnt), 32'h2);
        check("rerequest_nsel", 32'(ntt_intt_select), 32'h04);
        req[1] = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
